// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, inserts WAIT_N wait states, then
// commits to a byte-enabled word RAM and returns a one-cycle response pulse.
module dmem_responder #(
   parameter int AW     = 10,
   parameter int WAIT_N = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   localparam logic [3:0] CNT_INIT = 4'((WAIT_N > 0) ? WAIT_N - 1 : 0);

   generate
      if (WAIT_N < 0 || WAIT_N > 15) begin : g_bad_wait_n
         $error("dmem_responder: WAIT_N must be within 0..15");
      end
      if (AW < 1 || AW > 30) begin : g_bad_aw
         $error("dmem_responder: AW must be within 1..30");
      end
   endgenerate

   state_t      state;
   logic [3:0]  cnt;
   req_t        held;
   req_t        cur;
   logic        handshake;
   logic        commit;
   logic        acc_err;
   logic [AW-1:0] word;
   logic [31:0] mem [0:(1<<AW)-1];

   assign req_ready = (state == S_IDLE) && rst;
   assign handshake = req_valid && req_ready;

   // With WAIT_N=0 the commit edge is the handshake edge, so the live request is used.
   // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
   always_comb begin
      cur = held;
      if (state == S_IDLE) begin
         cur = '{we: req_we, be: req_be, addr: req_addr, wdata: req_wdata};
      end
   end

   assign commit  = (state == S_WAIT && cnt == 4'd0) || (WAIT_N == 0 && handshake);
   assign acc_err = (cur.addr[1:0] != 2'b00) || ((cur.addr >> (AW + 2)) != 32'd0);
   assign word    = cur.addr[AW+1:2];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         held      <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         if (commit) begin
            rsp_err   <= acc_err;
            rsp_rdata <= (!acc_err && !cur.we) ? mem[word] : 32'd0;
         end
         case (state)
            S_IDLE: begin
               if (handshake) begin
                  held <= cur;
                  if (WAIT_N == 0) begin
                     state <= S_RESP;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) state <= S_RESP;
               else             cnt   <= cnt - 4'd1;
            end
            S_RESP: begin
               state     <= S_IDLE;
               rsp_valid <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // NOTE: RAM contents are deliberately not reset; it stays a plain synchronous-write array.
   always_ff @(posedge clk) begin
      if (commit && cur.we && !acc_err) begin
         for (int b = 0; b < 4; b++) begin
            if (cur.be[b]) mem[word][8*b +: 8] <= cur.wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with WAIT_N=2 and one with WAIT_N=0,
// directed cases plus randomized traffic checked against an array-based memory model.
module tb_dmem_responder;

   localparam int WN0 = 2;
   localparam int WN1 = 0;

   logic        clk;
   logic        rst       [2];
   logic        req_valid [2];
   logic        req_we    [2];
   logic [3:0]  req_be    [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic        req_ready [2];
   logic        rsp_valid [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] ref_mem   [2][1024];
   bit          ref_known [2][1024];

   dmem_responder #(.AW(10), .WAIT_N(WN0)) u0 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_we(req_we[0]),
      .req_be(req_be[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_err(rsp_err[0])
   );

   dmem_responder #(.AW(10), .WAIT_N(WN1)) u1 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_we(req_we[1]),
      .req_be(req_be[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_err(rsp_err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One transaction on unit i; expectations come from the memory model.
   task automatic do_req(input int i, input int wn, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata, input string tag);
      bit          exp_err;
      bit          data_known;
      logic [31:0] exp_rdata;
      int          w;
      int          k;
      string       t;
      t          = $sformatf("u%0d %s", i, tag);
      exp_err    = (addr[1:0] != 2'b00) || (addr >= 32'h0000_1000);
      w          = int'(addr[11:2]);
      exp_rdata  = 32'd0;
      data_known = 1'b1;
      if (!exp_err && !we) begin
         exp_rdata  = ref_mem[i][w];
         data_known = ref_known[i][w];
      end
      if (!exp_err && we) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[i][w][8*b +: 8] = wdata[8*b +: 8];
         if (be == 4'hF) ref_known[i][w] = 1'b1;
      end

      @(negedge clk);
      req_valid[i] = 1'b1;
      req_we[i]    = we;
      req_be[i]    = be;
      req_addr[i]  = addr;
      req_wdata[i] = wdata;
      k = 0;
      while (!req_ready[i] && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready[i]) begin
         check({t, " accept"}, 32'd0, 32'd1);
         req_valid[i] = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_valid[i] = 1'b0;
      req_we[i]    = 1'($urandom_range(0, 1));
      req_be[i]    = 4'($urandom);
      req_addr[i]  = $urandom;
      req_wdata[i] = $urandom;

      for (k = 0; k < wn + 5; k++) begin
         @(negedge clk);
         if (rsp_valid[i]) break;
      end
      check({t, " latency"}, 32'(k), 32'(wn + 1));
      check({t, " err"}, 32'(rsp_err[i]), 32'(exp_err));
      if (data_known) check({t, " rdata"}, rsp_rdata[i], exp_rdata);
      @(negedge clk);
      check({t, " pulse"}, 32'(rsp_valid[i]), 32'd0);
   endtask

   // req_valid held high: accepts must be spaced wn+2 cycles, one response each.
   task automatic hold_test(input int i, input int wn);
      int          acc = 0;
      int          rsp = 0;
      int          last = -1;
      int          bad_gap = 0;
      int          bad_data = 0;
      int          win;
      logic [31:0] exp;
      string       t;
      t   = $sformatf("u%0d hold", i);
      win = 4 * (wn + 2);
      exp = ref_mem[i][4];
      @(negedge clk);
      req_valid[i] = 1'b1;
      req_we[i]    = 1'b0;
      req_be[i]    = 4'h0;
      req_addr[i]  = 32'h10;
      for (int c = 0; c < win; c++) begin
         if (c > 0) @(negedge clk);
         if (req_ready[i]) begin
            acc++;
            if (last >= 0 && c - last != wn + 2) bad_gap++;
            last = c;
         end
         if (rsp_valid[i]) begin
            rsp++;
            if (rsp_rdata[i] !== exp || rsp_err[i] !== 1'b0) bad_data++;
         end
      end
      req_valid[i] = 1'b0;
      for (int c = 0; c < wn + 3; c++) begin
         @(negedge clk);
         if (rsp_valid[i]) begin
            rsp++;
            if (rsp_rdata[i] !== exp || rsp_err[i] !== 1'b0) bad_data++;
         end
      end
      check({t, " accepts"}, 32'(acc), 32'd4);
      check({t, " responses"}, 32'(rsp), 32'd4);
      check({t, " gaps"}, 32'(bad_gap), 32'd0);
      check({t, " data"}, 32'(bad_data), 32'd0);
   endtask

   // Store interrupted by reset while waiting must be discarded.
   task automatic reset_mid_test(input int i);
      do_req(i, WN0, 1'b1, 4'hF, 32'h20, 32'h0000_0000, "pre-store 0x20");
      @(negedge clk);
      req_valid[i] = 1'b1;
      req_we[i]    = 1'b1;
      req_be[i]    = 4'hF;
      req_addr[i]  = 32'h20;
      req_wdata[i] = 32'h1234_5678;
      check($sformatf("u%0d rst-mid ready", i), 32'(req_ready[i]), 32'd1);
      @(posedge clk);
      #1;
      req_valid[i] = 1'b0;
      rst[i]       = 1'b0;
      #1;
      check($sformatf("u%0d rst-mid ready low", i), 32'(req_ready[i]), 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("u%0d rst-mid no rsp %0d", i, c), 32'(rsp_valid[i]), 32'd0);
      end
      rst[i] = 1'b1;
      do_req(i, WN0, 1'b0, 4'h0, 32'h20, 32'h0, "load 0x20 after rst");
   endtask

   task automatic random_test(input int i, input int wn, input int n);
      int          r;
      int          w;
      bit          we;
      logic [3:0]  be;
      logic [31:0] addr;
      for (int t = 0; t < n; t++) begin
         r    = int'($urandom_range(0, 9));
         w    = int'($urandom_range(0, 15));
         we   = 1'($urandom_range(0, 1));
         be   = 4'($urandom);
         addr = 32'(w * 4);
         if (r == 0) addr = addr | 32'($urandom_range(1, 3));
         if (r == 1) addr = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
         if (r > 1 && !ref_known[i][w]) begin
            we = 1'b1;
            be = 4'hF;
         end
         do_req(i, wn, we, be, addr, $urandom, $sformatf("rand%0d", t));
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i]       = 1'b0;
         req_valid[i] = 1'b1;
         req_we[i]    = 1'b0;
         req_be[i]    = 4'h0;
         req_addr[i]  = 32'h10;
         req_wdata[i] = 32'h0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("u%0d reset ready", i), 32'(req_ready[i]), 32'd0);
         check($sformatf("u%0d reset rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
         check($sformatf("u%0d reset rdata", i), rsp_rdata[i], 32'd0);
         check($sformatf("u%0d reset err", i), 32'(rsp_err[i]), 32'd0);
      end
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0;
         rst[i]       = 1'b1;
      end

      for (int i = 0; i < 2; i++) begin
         int wn;
         wn = (i == 0) ? WN0 : WN1;
         do_req(i, wn, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, "store DEADBEEF");
         do_req(i, wn, 1'b0, 4'h0, 32'h10, 32'h0, "load 0x10");
         check($sformatf("u%0d model 0x10", i), ref_mem[i][4], 32'hDEAD_BEEF);
         do_req(i, wn, 1'b1, 4'b0001, 32'h10, 32'h0000_00AA, "partial store");
         do_req(i, wn, 1'b0, 4'h0, 32'h10, 32'h0, "load partial");
         do_req(i, wn, 1'b0, 4'h0, 32'h13, 32'h0, "load misaligned");
         do_req(i, wn, 1'b0, 4'h0, 32'h0000_1000, 32'h0, "load out of range");
         do_req(i, wn, 1'b1, 4'hF, 32'h0000_1010, 32'h5555_5555, "store out of range");
         do_req(i, wn, 1'b1, 4'h0, 32'h10, 32'hFFFF_FFFF, "store be0");
         do_req(i, wn, 1'b0, 4'h0, 32'h10, 32'h0, "load unchanged");
         hold_test(i, wn);
      end

      reset_mid_test(0);

      random_test(0, WN0, 60);
      random_test(1, WN1, 60);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
